// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_DEFAULT_CLK_PER_BAUD = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Store-path write port and serial-side status of the buffered UART transmitter.
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic                      wr_en;
  logic [UART_DATA_BITS-1:0] wr_data;
  logic                      tx_ready;
  logic                      txd;
  logic                      busy;

  modport master (output wr_en, wr_data, input tx_ready, txd, busy);
  modport slave  (input wr_en, wr_data, output tx_ready, txd, busy);
endinterface

// File: rtl/uart_tx_buf.sv
// Synchronous FIFO feeding the UART framer; pointers carry an extra wrap bit.
module uart_tx_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok_c = push && !full_c;
  assign pop_ok_c  = pop && !empty_c;
  assign head_c    = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage is data-only; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO drained by an LSB-first 8N1 framer.
// Defining UART_TX_PARITY_EN adds an even-parity bit (8E1 frames).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BAUD = UART_DEFAULT_CLK_PER_BAUD,
  parameter int unsigned DEPTH        = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned BAUD_W = $clog2(CLK_PER_BAUD);
  localparam int unsigned IDX_W  = $clog2(UART_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BAUD - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  tx_state_t                 state_q, state_d;
  logic [UART_DATA_BITS-1:0] sh_q, sh_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      txd_q, txd_d;
  logic                      busy_q, busy_d;
  logic                      pop_c, full_c, empty_c, baud_end_c;
  logic [UART_DATA_BITS-1:0] head_c;
`ifdef UART_TX_PARITY_EN
  logic                      par_q, par_d;
`endif

  uart_tx_buf #(
    .DEPTH(DEPTH),
    .WIDTH(UART_DATA_BITS)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .push   (bus.wr_en),
    .pop    (pop_c),
    .wr_data(bus.wr_data),
    .head_c (head_c),
    .full_c (full_c),
    .empty_c(empty_c)
  );

  assign bus.tx_ready = !full_c;
  assign bus.txd      = txd_q;
  assign bus.busy     = busy_q;
  assign baud_end_c   = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      baud_q  <= '0;
      idx_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Framer next state; STOP chains straight into START when more data is queued.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    pop_c   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) baud_d = baud_end_c ? '0 : baud_q + BAUD_W'(1);

    case (state_q)
      IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          sh_d    = head_c;
          baud_d  = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head_c;
`endif
        end
      end
      START: begin
        if (baud_end_c) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_end_c) begin
          sh_d  = sh_q >> 1;
          idx_d = idx_q + IDX_W'(1);
`ifdef UART_TX_PARITY_EN
          if (idx_q == IDX_LAST) state_d = PARITY;
`else
          if (idx_q == IDX_LAST) state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end_c) state_d = STOP;
      end
`endif
      STOP: begin
        if (baud_end_c) begin
          if (!empty_c) begin
            pop_c   = 1'b1;
            sh_d    = head_c;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head_c;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level decoded from the current state, then registered for a clean pin.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sh_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = par_q;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  assign busy_d = (state_d != IDLE) || !empty_c || (bus.wr_en && !full_c);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo at CLK_PER_BAUD=4, DEPTH=16.
// Define UART_TX_PARITY_EN for the 8E1 variant.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;
  localparam int CAP_N     = 18 * FRAME_CYC;

  logic clk = 1'b0;
  logic rst;
  int   n_asserts = 0;
  int   n_fail    = 0;
  logic cap_en    = 1'b0;
  logic cap[$];

  uart_tx_fifo_if bus();

  uart_tx_fifo #(
    .CLK_PER_BAUD(CPB),
    .DEPTH       (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (cap_en) cap.push_back(bus.txd);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for bit slot k of a frame carrying byte b.
  function automatic logic exp_level(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Call on the negedge just before the first start-bit cycle.
  task automatic check_frame(input logic [7:0] b, input bit last);
    for (int k = 0; k < NBITS; k++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        check($sformatf("txd_%02h_bit%0d_c%0d", b, k, c), 32'(bus.txd), 32'(exp_level(b, k)));
        check($sformatf("busy_%02h_bit%0d_c%0d", b, k, c), 32'(bus.busy),
              32'(!(last && k == NBITS - 1 && c == CPB - 1)));
      end
    end
  endtask

  initial begin
    logic [7:0] got;
    logic       idle_ok;
    int         e;
    int         base;

    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(bus.txd), 32'd1);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_txd", 32'(bus.txd), 32'd1);
    end

    // Single byte 0x55
    push_byte(8'h55);
    check("single_busy_on_push", 32'(bus.busy), 32'd1);
    check("single_txd_n0", 32'(bus.txd), 32'd1);
    @(negedge clk);
    check("single_txd_n1", 32'(bus.txd), 32'd1);
    check_frame(8'h55, 1'b1);
    @(negedge clk);
    check("single_after_txd", 32'(bus.txd), 32'd1);
    check("single_after_busy", 32'(bus.busy), 32'd0);
    repeat (5) @(negedge clk);

    // Back-to-back 0xA3, 0x0F
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA3;
    @(negedge clk);
    bus.wr_data = 8'h0F;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    check("b2b_busy", 32'(bus.busy), 32'd1);
    check_frame(8'hA3, 1'b0);
    check_frame(8'h0F, 1'b1);
    repeat (5) @(negedge clk);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 has three ones, so even parity bit is 1
    push_byte(8'h07);
    @(negedge clk);
    check_frame(8'h07, 1'b1);
    repeat (5) @(negedge clk);
`endif

    // Fill and overflow: 0xC5 starts transmitting, then 0x00..0x10 back-to-back
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hC5;
    @(negedge clk);
    for (int i = 0; i <= 16; i++) begin
      bus.wr_data = 8'(i);
      @(negedge clk);
      if (i == 0) cap_en = 1'b1;
      check($sformatf("fill_tx_ready_%0d", i), 32'(bus.tx_ready), 32'(i < 15));
    end
    bus.wr_en = 1'b0;
    e = 17;
    while (cap.size() < CAP_N && e < 5000) begin
      @(negedge clk);
      e++;
      if (e == FRAME_CYC)     check("full_before_pop", 32'(bus.tx_ready), 32'd0);
      if (e == FRAME_CYC + 1) check("ready_after_pop", 32'(bus.tx_ready), 32'd1);
    end
    cap_en = 1'b0;
    check("capture_len", 32'(cap.size() >= CAP_N), 32'd1);
    if (cap.size() >= CAP_N) begin
      for (int f = 0; f < 17; f++) begin
        base = f * FRAME_CYC;
        for (int d = 0; d < 8; d++) got[d] = cap[base + (d + 1) * CPB + CPB / 2];
        check($sformatf("ovf_start_%0d", f), 32'(cap[base + CPB / 2]), 32'd0);
        check($sformatf("ovf_byte_%0d", f), 32'(got), (f == 0) ? 32'hC5 : 32'(f - 1));
        check($sformatf("ovf_stop_%0d", f), 32'(cap[base + (NBITS - 1) * CPB + CPB / 2]), 32'd1);
      end
      idle_ok = 1'b1;
      for (int j = 17 * FRAME_CYC; j < CAP_N; j++) idle_ok &= cap[j];
      check("ovf_dropped_byte_absent", 32'(idle_ok), 32'd1);
    end
    check("ovf_busy_end", 32'(bus.busy), 32'd0);
    repeat (5) @(negedge clk);

    // Reset during DATA bit 3 of 0xF0 (bit 3 = 0)
    push_byte(8'hF0);
    repeat (19) @(negedge clk);
    check("midframe_bit3_low", 32'(bus.txd), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_txd", 32'(bus.txd), 32'd1);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("post_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("post_rst_txd", 32'(bus.txd), 32'd1);
      check("post_rst_busy", 32'(bus.busy), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
